// File: rtl/branch_target_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : branch_target_buffer
// Purpose  : Direct-mapped branch target buffer for the fetch stage.
//            Combinational zero-latency lookup of FPCidx that produces the
//            predicted next PC. Trained from X-stage branch resolution using
//            allocate-on-taken, with a same-cycle bypass.
//            PCs are word addresses, so the sequential next PC is PC+1.
// Ports    : clock, reset (async, active-low)
//            FPCidx, shouldTakeBranch            - fetch lookup
//            Xbranch, XPCidx, Xtarget,
//            XactualTaken                        - X-stage training
//            flush                               - synchronous invalidate-all
//            btbHit, predictedTarget, nextPC     - lookup results
//            lookupCount, hitCount, evictCount   - only with BTB_STATS_EN
// Options  : `define BTB_STATS_EN to add saturating statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_target_buffer #(
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 32 - IDX_BITS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] FPCidx,
  input  logic        shouldTakeBranch,
  input  logic        Xbranch,
  input  logic [31:0] XPCidx,
  input  logic [31:0] Xtarget,
  input  logic        XactualTaken,
  input  logic        flush,
  output logic        btbHit,
  output logic [31:0] predictedTarget,
  output logic [31:0] nextPC
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] lookupCount,
  output logic [31:0] hitCount,
  output logic [15:0] evictCount
`endif
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_mem    [ENTRIES];
  logic [31:0]         target_mem [ENTRIES];

  logic [IDX_BITS-1:0] f_idx;
  logic [IDX_BITS-1:0] x_idx;
  logic [TAG_BITS-1:0] f_tag;
  logic [TAG_BITS-1:0] x_tag;
  logic                write_en;
  logic                array_hit;
  logic                bypass_hit;

  assign f_idx = FPCidx[IDX_BITS-1:0];
  assign f_tag = FPCidx[31:IDX_BITS];
  assign x_idx = XPCidx[IDX_BITS-1:0];
  assign x_tag = XPCidx[31:IDX_BITS];

  // Only taken branches allocate; a flush cancels the write in the same cycle.
  assign write_en = Xbranch & XactualTaken & ~flush;

  assign array_hit = valid_q[f_idx] & (tag_mem[f_idx] == f_tag);

  // Forward the in-flight write when it targets exactly the fetched PC.
  // An index-only alias is not forwarded: the old occupant is still visible.
  // Gating with reset keeps the outputs quiet while reset is held.
  assign bypass_hit = write_en & reset & (XPCidx == FPCidx);

  assign btbHit = array_hit | bypass_hit;

  always_comb begin
    predictedTarget = 32'd0;
    if (bypass_hit) begin
      predictedTarget = Xtarget;
    end else if (array_hit) begin
      predictedTarget = target_mem[f_idx];
    end
  end

  assign nextPC = (btbHit & shouldTakeBranch) ? predictedTarget : (FPCidx + 32'd1);

  // Valid bits: the only state that needs a reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (write_en) begin
      valid_q[x_idx] <= 1'b1;
    end
  end

  // Tag/target payload. Not reset; suppressed while reset is held so an
  // update racing an asserted reset leaves no trace.
  always_ff @(posedge clock) begin
    if (write_en && reset) begin
      tag_mem[x_idx]    <= x_tag;
      target_mem[x_idx] <= Xtarget;
    end
  end

`ifdef BTB_STATS_EN
  logic evict_event;

  // A taken write that displaces a live entry belonging to another branch.
  assign evict_event = write_en & valid_q[x_idx] & (tag_mem[x_idx] != x_tag);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lookupCount <= 32'd0;
      hitCount    <= 32'd0;
      evictCount  <= 16'd0;
    end else begin
      if (lookupCount != 32'hFFFF_FFFF) begin
        lookupCount <= lookupCount + 32'd1;
      end
      if (btbHit && (hitCount != 32'hFFFF_FFFF)) begin
        hitCount <= hitCount + 32'd1;
      end
      if (evict_event && (evictCount != 16'hFFFF)) begin
        evictCount <= evictCount + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_branch_target_buffer
// Purpose  : Self-checking bench for branch_target_buffer. Stimulus pushes the
//            expected lookup result into a queue; a monitor on the falling
//            edge pops and compares. The reference keeps, per index, the last
//            taken branch PC and its target.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_target_buffer;

  localparam int ENTRIES = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] FPCidx;
  logic        shouldTakeBranch;
  logic        Xbranch;
  logic [31:0] XPCidx;
  logic [31:0] Xtarget;
  logic        XactualTaken;
  logic        flush;
  logic        btbHit;
  logic [31:0] predictedTarget;
  logic [31:0] nextPC;
`ifdef BTB_STATS_EN
  logic [31:0] lookupCount;
  logic [31:0] hitCount;
  logic [15:0] evictCount;
`endif

  branch_target_buffer dut (
    .clock            (clock),
    .reset            (reset),
    .FPCidx           (FPCidx),
    .shouldTakeBranch (shouldTakeBranch),
    .Xbranch          (Xbranch),
    .XPCidx           (XPCidx),
    .Xtarget          (Xtarget),
    .XactualTaken     (XactualTaken),
    .flush            (flush),
    .btbHit           (btbHit),
    .predictedTarget  (predictedTarget),
    .nextPC           (nextPC)
`ifdef BTB_STATS_EN
    ,
    .lookupCount      (lookupCount),
    .hitCount         (hitCount),
    .evictCount       (evictCount)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        hit;
    logic [31:0] tgt;
    logic [31:0] npc;
    logic [31:0] fpc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference: each slot remembers the full PC of the last taken branch
  // mapped there, so a lookup hits only on an exact PC match.
  bit          m_valid [ENTRIES];
  logic [31:0] m_pc    [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int unsigned m_lookups;
  int unsigned m_hits;
  int unsigned m_evicts;

  logic [31:0] pool [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_lookups = 0;
    m_hits    = 0;
    m_evicts  = 0;
  endfunction

  // Applies one cycle of inputs, queues the expected lookup, advances the
  // reference across the rising edge.
  task automatic drive(input logic r, input logic [31:0] fpc, input logic stb,
                       input logic xb, input logic [31:0] xpc, input logic [31:0] xt,
                       input logic xtk, input logic fl);
    exp_t e;
    int   fi;
    int   xi;
    reset = r; FPCidx = fpc; shouldTakeBranch = stb; Xbranch = xb;
    XPCidx = xpc; Xtarget = xt; XactualTaken = xtk; flush = fl;
    if (!r) model_reset();
    fi    = int'(fpc % ENTRIES);
    e.fpc = fpc;
    if (r && xb && xtk && !fl && (xpc == fpc)) begin
      e.hit = 1'b1; e.tgt = xt;
    end else if (r && m_valid[fi] && (m_pc[fi] == fpc)) begin
      e.hit = 1'b1; e.tgt = m_tgt[fi];
    end else begin
      e.hit = 1'b0; e.tgt = 32'd0;
    end
    e.npc = (e.hit && stb) ? e.tgt : fpc + 32'd1;
    exp_q.push_back(e);
    @(posedge clock);
    if (r) begin
      m_lookups++;
      if (e.hit) m_hits++;
      if (fl) begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      end else if (xb && xtk) begin
        xi = int'(xpc % ENTRIES);
        if (m_valid[xi] && (m_pc[xi] != xpc)) m_evicts++;
        m_valid[xi] = 1'b1;
        m_pc[xi]    = xpc;
        m_tgt[xi]   = xt;
      end
    end
    #1;
  endtask

  task automatic look(input logic [31:0] fpc, input logic stb);
    drive(1'b1, fpc, stb, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    drive(1'b1, 32'h0000_0FF0, 1'b0, 1'b1, pc, tgt, tk, 1'b0);
  endtask

  // Monitor: the lookup is valid every cycle; sample mid-cycle.
  always @(negedge clock) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("btbHit@%h", e.fpc), 32'(btbHit), 32'(e.hit));
      check($sformatf("predictedTarget@%h", e.fpc), predictedTarget, e.tgt);
      check($sformatf("nextPC@%h", e.fpc), nextPC, e.npc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] fpc_r;
    logic [31:0] xpc_r;
    pool[0] = 32'h40; pool[1] = 32'h50; pool[2] = 32'h23; pool[3] = 32'h33;
    pool[4] = 32'h12; pool[5] = 32'h22; pool[6] = 32'hFFFF_FFFF; pool[7] = 32'h0F;
    reset = 1'b0; FPCidx = '0; shouldTakeBranch = 1'b0; Xbranch = 1'b0;
    XPCidx = '0; Xtarget = '0; XactualTaken = 1'b0; flush = 1'b0;
    model_reset();
    @(posedge clock); #1;

    // Held in reset, then released: empty buffer.
    drive(1'b0, 32'h40, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    look(32'h40, 1'b1);

    // Basic train and lookup, with and without a taken prediction.
    train(32'h40, 32'h100, 1'b1);
    look(32'h40, 1'b1);
    look(32'h40, 1'b0);

    // Conflict eviction on index 0.
    train(32'h50, 32'h200, 1'b1);
    look(32'h40, 1'b1);
    look(32'h50, 1'b1);

    // Same-cycle bypass, then the same with flush on a clean buffer.
    drive(1'b1, 32'h23, 1'b1, 1'b1, 32'h23, 32'h80, 1'b1, 1'b0);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    drive(1'b1, 32'h23, 1'b1, 1'b1, 32'h23, 32'h80, 1'b1, 1'b1);
    look(32'h23, 1'b1);

    // Not-taken update keeps the entry; reset mid-run drops it at once,
    // including the bypass and the write racing it.
    train(32'h40, 32'h100, 1'b1);
    train(32'h40, 32'h999, 1'b0);
    look(32'h40, 1'b1);
    drive(1'b0, 32'h40, 1'b1, 1'b1, 32'h40, 32'h300, 1'b1, 1'b0);
    look(32'h40, 1'b1);

    // Wrap at the top of the address space, and a trained top entry.
    look(32'hFFFF_FFFF, 1'b1);
    train(32'hFFFF_FFFF, 32'h10, 1'b1);
    look(32'hFFFF_FFFF, 1'b1);

    // Index alias in flight: no bypass, old occupant visible until the edge.
    train(32'h12, 32'h500, 1'b1);
    drive(1'b1, 32'h12, 1'b1, 1'b1, 32'h22, 32'h600, 1'b1, 1'b0);
    look(32'h22, 1'b1);
    look(32'h12, 1'b1);

    // Xbranch low: no bypass and no write.
    drive(1'b1, 32'h7, 1'b1, 1'b0, 32'h7, 32'h777, 1'b1, 1'b0);
    look(32'h7, 1'b1);

`ifdef BTB_STATS_EN
    // Ten lookups, four hits, one conflict eviction.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 32'h1, 1'b0, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0);
    look(32'h40, 1'b1);
    look(32'h40, 1'b1);
    drive(1'b1, 32'h5, 1'b0, 1'b1, 32'h50, 32'h200, 1'b1, 1'b0);
    look(32'h40, 1'b1);
    look(32'h50, 1'b1);
    look(32'h50, 1'b1);
    look(32'h7, 1'b0);
    look(32'h7, 1'b0);
    look(32'h7, 1'b0);
    check("lookupCount_plan", lookupCount, 32'd10);
    check("hitCount_plan", hitCount, 32'd4);
    check("evictCount_plan", 32'(evictCount), 32'd1);
`endif

    // Randomized traffic over a small set of aliasing PCs.
    for (int n = 0; n < 400; n++) begin
      fpc_r = pool[$urandom_range(0, 7)];
      xpc_r = ($urandom_range(0, 3) == 0) ? fpc_r : pool[$urandom_range(0, 7)];
      drive(($urandom_range(0, 59) != 0), fpc_r, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), xpc_r, $urandom,
            1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0));
    end

`ifdef BTB_STATS_EN
    check("lookupCount_rand", lookupCount, m_lookups);
    check("hitCount_rand", hitCount, m_hits);
    check("evictCount_rand", 32'(evictCount), 32'(m_evicts[15:0]));
`endif

    for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(negedge clock);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
